if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 186 ++++++++++++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Issues one instruction-memory read
//                at a time, presents the returned word to decode through a
//                one-slot output register, and parks one extra word in a hold
//                buffer when decode is stalled. Redirects override all other
//                activity; a response to a request that was already in flight
//                when a redirect arrived is dropped through a kill flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   rising-edge clock
//    rst            in   1   synchronous active-high reset
//    stall_i        in   1   decode not accepting; output bundle holds
//    redirect_i     in   1   branch/jump redirect strobe
//    redirect_pc_i  in  32   redirect target (low two bits ignored)
//    imem_req_o     out  1   instruction-memory request valid
//    imem_addr_o    out 32   request address, word aligned
//    imem_ready_i   in   1   memory accepts request this cycle
//    imem_rvalid_i  in   1   read data valid
//    imem_rdata_i   in  32   instruction word
//    pc_o           out 32   address of inst_o
//    inst_o         out 32   instruction to decode
//    valid_o        out  1   pc_o/inst_o hold a valid instruction
// ============================================================================
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] C_PC_STEP   = 32'd4;
    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q,     state_d;
    logic [31:0] fetch_pc_q,  fetch_pc_d;
    logic        kill_q,      kill_d;
    logic [31:0] hold_pc_q,   hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] inst_q,      inst_d;
    logic        valid_q,     valid_d;

    logic        w_accept;
    logic        w_slot_free;
    logic        w_transfer;
    logic [31:0] w_redirect_target;
    logic [31:0] w_fetch_pc_next;

    assign w_accept          = (state_q == S_ISSUE) && imem_ready_i;
    assign w_slot_free       = !valid_q || !stall_i;
    assign w_transfer        = valid_q && !stall_i;
    assign w_redirect_target = redirect_pc_i & C_WORD_MASK;
    // 32-bit add wraps 0xFFFF_FFFC to 0x0000_0000 on its own.
    assign w_fetch_pc_next   = fetch_pc_q + C_PC_STEP;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        kill_d      = kill_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;

        // A consumed slot empties unless a new word lands in it below.
        if (w_transfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_ISSUE: begin
                if (redirect_i) begin
                    fetch_pc_d = w_redirect_target;
                    if (w_accept) begin
                        // The accepted request is for the old path.
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (w_accept) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    fetch_pc_d = w_redirect_target;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        // Stale response: drop it, fetch_pc already holds
                        // the redirect target.
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else if (w_slot_free) begin
                        pc_d       = fetch_pc_q;
                        inst_d     = imem_rdata_i;
                        valid_d    = 1'b1;
                        fetch_pc_d = w_fetch_pc_next;
                        state_d    = S_ISSUE;
                    end else begin
                        hold_pc_d   = fetch_pc_q;
                        hold_inst_d = imem_rdata_i;
                        fetch_pc_d  = w_fetch_pc_next;
                        state_d     = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_i) begin
                    fetch_pc_d = w_redirect_target;
                    state_d    = S_ISSUE;
                end else if (!stall_i) begin
                    pc_d    = hold_pc_q;
                    inst_d  = hold_inst_q;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            default: begin
                state_d = S_ISSUE;
            end
        endcase

        if (redirect_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ISSUE;
            fetch_pc_q  <= 32'h0000_0000;
            kill_q      <= 1'b0;
            hold_pc_q   <= 32'h0000_0000;
            hold_inst_q <= 32'h0000_0000;
            pc_q        <= 32'h0000_0000;
            inst_q      <= 32'h0000_0000;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_q      <= kill_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    // Request is suppressed while rst is high, even in the first reset cycle
    // when state_q may still reflect an abandoned transaction.
    assign imem_req_o  = (state_q == S_ISSUE) && !rst;
    assign imem_addr_o = fetch_pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign valid_o     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed bench for if_stage. A small memory model answers
//                each accepted request one cycle later with data addr+0x10;
//                the bench can withhold ready or rvalid to hold the fetch
//                stage in ISSUE or WAIT. Expected values are hand-derived.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    // memory model controls and state
    logic        mem_ready;
    logic        mem_rvalid_en;
    logic        r_pend;
    logic [31:0] r_paddr;

    int n_checks;
    int n_errors;

    if_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ready_i  = mem_ready;
    assign imem_rvalid_i = r_pend && mem_rvalid_en;
    assign imem_rdata_i  = r_paddr + 32'h10;

    always @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else begin
            if (r_pend && mem_rvalid_en) r_pend <= 1'b0;
            if (imem_req_o && imem_ready_i) begin
                r_pend  <= 1'b1;
                r_paddr <= imem_addr_o;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one cycle; sample and drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        check_eq({tag, ".pc"}, pc_o, pc);
        check_eq({tag, ".inst"}, inst_o, inst);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
        if (req) check_eq({tag, ".addr"}, imem_addr_o, addr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_out("rst_out", 1'b0, 32'h0, 32'h0);
        check_req("rst_req", 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check_req("first_req", 1'b1, 32'h0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_ready     = 1'b1;
        mem_rvalid_en = 1'b1;
        r_paddr       = 32'h0;

        // ---- streaming fetch, no stall ----
        do_reset();
        tick(); check_req("s1_t1", 1'b0, 32'h0); check_eq("s1_t1.valid", {31'd0, valid_o}, 32'd0);
        tick(); check_out("s1_t2", 1'b1, 32'h0, 32'h10); check_req("s1_t2", 1'b1, 32'h4);
        tick(); check_eq("s1_t3.valid", {31'd0, valid_o}, 32'd0);
        tick(); check_out("s1_t4", 1'b1, 32'h4, 32'h14);
        tick(); check_eq("s1_t5.valid", {31'd0, valid_o}, 32'd0);
        tick(); check_out("s1_t6", 1'b1, 32'h8, 32'h18);

        // ---- stall with word parked in the hold buffer ----
        do_reset();
        stall_i = 1'b1;
        tick();
        tick(); check_out("s2_t2", 1'b1, 32'h0, 32'h10); check_req("s2_t2", 1'b1, 32'h4);
        tick(); check_out("s2_t3", 1'b1, 32'h0, 32'h10);
        tick(); check_out("s2_t4", 1'b1, 32'h0, 32'h10); check_req("s2_t4", 1'b0, 32'h0);
        tick(); check_out("s2_t5", 1'b1, 32'h0, 32'h10); check_req("s2_t5", 1'b0, 32'h0);
        stall_i = 1'b0;
        tick(); check_out("s2_t6", 1'b1, 32'h4, 32'h14); check_req("s2_t6", 1'b1, 32'h8);

        // ---- redirect to 0x103 while waiting for 0x8 ----
        mem_rvalid_en = 1'b0;
        tick(); check_req("s3_wait", 1'b0, 32'h0); check_eq("s3_wait.valid", {31'd0, valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        tick(); check_eq("s3_kill.valid", {31'd0, valid_o}, 32'd0);
        redirect_i = 1'b0; mem_rvalid_en = 1'b1;
        tick(); check_eq("s3_drop.valid", {31'd0, valid_o}, 32'd0); check_req("s3_drop", 1'b1, 32'h100);
        tick();
        tick(); check_out("s3_out", 1'b1, 32'h100, 32'h110);

        // ---- redirect coincident with rvalid ----
        tick(); check_eq("s4_rv", {31'd0, imem_rvalid_i}, 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick(); check_eq("s4_drop.valid", {31'd0, valid_o}, 32'd0); check_req("s4_drop", 1'b1, 32'h200);
        redirect_i = 1'b0;
        tick();
        tick(); check_out("s4_out", 1'b1, 32'h200, 32'h210);

        // ---- redirect to 0xFFFF_FFFC with acceptance in the same cycle ----
        check_req("s5_pre", 1'b1, 32'h204);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick(); check_eq("s5_kill.valid", {31'd0, valid_o}, 32'd0); check_req("s5_kill", 1'b0, 32'h0);
        redirect_i = 1'b0;
        tick(); check_req("s5_tgt", 1'b1, 32'hFFFF_FFFC); check_eq("s5_tgt.valid", {31'd0, valid_o}, 32'd0);
        tick();
        tick(); check_out("s5_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_000C); check_req("s5_wrap", 1'b1, 32'h0);
        tick();
        tick(); check_out("s5_zero", 1'b1, 32'h0, 32'h10);

        // ---- ISSUE without acceptance, then redirect in ISSUE ----
        mem_ready = 1'b0;
        tick(); check_req("s6_stay", 1'b1, 32'h4); check_eq("s6_stay.valid", {31'd0, valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        tick(); check_req("s6_redir", 1'b1, 32'h300);
        redirect_i = 1'b0; mem_ready = 1'b1;
        tick();
        tick(); check_out("s6_out", 1'b1, 32'h300, 32'h310);

        // ---- reset while in HOLD ----
        stall_i = 1'b1;
        tick();
        tick(); check_req("s7_hold", 1'b0, 32'h0); check_out("s7_hold", 1'b1, 32'h300, 32'h310);
        rst = 1'b1;
        tick(); check_out("s7_rst", 1'b0, 32'h0, 32'h0); check_req("s7_rst", 1'b0, 32'h0);
        rst = 1'b0; stall_i = 1'b0;
        #1; check_req("s7_first", 1'b1, 32'h0);
        tick();
        tick(); check_out("s7_out", 1'b1, 32'h0, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
